jam_cost_port_arbiter: RTL and testbench



---
 rtl/jam_cost_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_jam_cost_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_port_arbiter.sv
// ---------------------------------------------------------------------------
// jam_cost_port_arbiter
//
// Purpose:
//   Shares the single cost-table read port (W/J out, Cost in) between NREQ
//   permutation-evaluation engines. Arbitration is round-robin at burst
//   granularity: once an engine is granted a multi-beat burst it keeps the
//   port until its last beat. Each accepted beat drives W/J for one cycle,
//   and the Cost sampled one cycle later is routed back to the owner.
//
// Ports:
//   CLK        in   1         clock, all state updates on posedge
//   RST        in   1         synchronous active-low reset
//   req        in   NREQ      per-engine read request
//   req_w      in   NREQ*IDW  per-engine worker index, slice i = [i*IDW +: IDW]
//   req_j      in   NREQ*IDW  per-engine job index, slice i = [i*IDW +: IDW]
//   req_last   in   NREQ      beat is the final beat of the engine's burst
//   gnt        out  NREQ      one-hot (or zero) grant, combinational
//   W          out  IDW       registered worker index to the cost table
//   J          out  IDW       registered job index to the cost table
//   Cost       in   CW        cost-table data, valid the cycle after W/J update
//   rsp_valid  out  NREQ      one-hot registered response strobe
//   rsp_cost   out  CW        registered cost returned to the engine
//   busy       out  1         burst locked or response pending
// ---------------------------------------------------------------------------
module jam_cost_port_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3,
  parameter int CW   = 7
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*IDW-1:0] req_w,
  input  logic [NREQ*IDW-1:0] req_j,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     gnt,
  output logic [IDW-1:0]      W,
  output logic [IDW-1:0]      J,
  input  logic [CW-1:0]       Cost,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [CW-1:0]       rsp_cost,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_e;

  arbState_e         state_q, state_d;
  logic [PW-1:0]     rrPtr_q, rrPtr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     tag_q;
  logic              pend_q;
  logic [IDW-1:0]    w_q, j_q;
  logic [NREQ-1:0]   rspValid_q;
  logic [CW-1:0]     rspCost_q;

  logic [PW-1:0]     grantIdx;
  logic [PW-1:0]     nextPtr;
  logic              accept;
  logic              acceptLast;
  logic [NREQ-1:0]   tagOneHot;

  // Grant selection. While locked the owner keeps the grant even if it drops
  // req, which produces a bubble rather than handing the port to someone else.
  // In IDLE the first requester at or after rrPtr_q wins, wrapping around.
  // Reset forces the grant low so no beat can be accepted during reset.
  always_comb begin
    logic          found;
    int            idx;
    logic [PW-1:0] idxP;
    gnt      = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    idxP     = '0;
    if (RST) begin
      if (state_q == LOCKED) begin
        gnt[owner_q] = 1'b1;
        grantIdx     = owner_q;
      end else begin
        for (int off = 0; off < NREQ; off++) begin
          idx  = (int'(rrPtr_q) + off) % NREQ;
          idxP = PW'(idx);
          if (!found && req[idxP]) begin
            found     = 1'b1;
            gnt[idxP] = 1'b1;
            grantIdx  = idxP;
          end
        end
      end
    end
  end

  assign accept     = |(req & gnt);
  assign acceptLast = req_last[grantIdx];
  assign nextPtr    = (grantIdx == PW'(NREQ - 1)) ? '0 : grantIdx + PW'(1);
  assign tagOneHot  = NREQ'(1) << tag_q;

  // Next-state logic. A single-beat burst stays in IDLE and just advances the
  // round-robin pointer; a multi-beat burst locks the port to its engine.
  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acceptLast) begin
            rrPtr_d = nextPtr;
          end else begin
            state_d = LOCKED;
            owner_d = grantIdx;
          end
        end
      end
      LOCKED: begin
        if (accept && acceptLast) begin
          state_d = IDLE;
          rrPtr_d = nextPtr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. The index registers only load on an
  // accepted beat; pend_q marks that next cycle's Cost belongs to tag_q.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      owner_q    <= '0;
      tag_q      <= '0;
      pend_q     <= 1'b0;
      w_q        <= '0;
      j_q        <= '0;
      rspValid_q <= '0;
      rspCost_q  <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      owner_q <= owner_d;
      pend_q  <= accept;
      if (accept) begin
        w_q   <= req_w[int'(grantIdx)*IDW +: IDW];
        j_q   <= req_j[int'(grantIdx)*IDW +: IDW];
        tag_q <= grantIdx;
      end
      rspValid_q <= pend_q ? tagOneHot : '0;
      if (pend_q) begin
        rspCost_q <= Cost;
      end
    end
  end

  assign W         = w_q;
  assign J         = j_q;
  assign rsp_valid = rspValid_q;
  assign rsp_cost  = rspCost_q;
  assign busy      = (state_q == LOCKED) | pend_q;

endmodule

// File: tb/tb_jam_cost_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jam_cost_port_arbiter
//
// Directed bench for the cost-port arbiter. The cost table is modelled as
// Cost = W*8 + J + 13, so Cost(3,5) = 42. Inputs change 1ns after the rising
// edge and outputs are sampled there too, away from the active edge.
// ---------------------------------------------------------------------------
module tb_jam_cost_port_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
  localparam int CW   = 7;

  logic                CLK;
  logic                RST;
  logic [NREQ-1:0]     req;
  logic [NREQ*IDW-1:0] req_w;
  logic [NREQ*IDW-1:0] req_j;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      W;
  logic [IDW-1:0]      J;
  logic [CW-1:0]       Cost;
  logic [NREQ-1:0]     rsp_valid;
  logic [CW-1:0]       rsp_cost;
  logic                busy;

  int checks;
  int errors;

  jam_cost_port_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW),
    .CW  (CW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .req_w    (req_w),
    .req_j    (req_j),
    .req_last (req_last),
    .gnt      (gnt),
    .W        (W),
    .J        (J),
    .Cost     (Cost),
    .rsp_valid(rsp_valid),
    .rsp_cost (rsp_cost),
    .busy     (busy)
  );

  // Free-running clock, 10ns period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cost-table model driven from the addresses the arbiter presents.
  assign Cost = CW'(int'(W) * 8 + int'(J) + 13);

  function automatic logic [CW-1:0] costOf(input int w, input int j);
    return CW'(w * 8 + j + 13);
  endfunction

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setEngine(input int e, input int w, input int j, input logic last);
    req_w[e*IDW +: IDW] = IDW'(w);
    req_j[e*IDW +: IDW] = IDW'(j);
    req_last[e]         = last;
  endtask

  task automatic do_reset();
    RST      = 1'b0;
    req      = '0;
    req_w    = '0;
    req_j    = '0;
    req_last = '0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
    end
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_rsp_valid: got %b expected %b", rsp_valid, 4'b0000);
    end
    checks++;
    if (W !== 3'd0 || J !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_wj: got W=%0d J=%0d expected W=0 J=0", W, J);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_release_gnt: got %b expected %b", gnt, 4'b0001);
    end
    req = '0;
    tick();
  endtask

  task automatic test_single_beat();
    do_reset();
    setEngine(2, 3, 5, 1'b1);
    req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_gnt: got %b expected %b", gnt, 4'b0100);
    end
    tick();
    req = '0;
    checks++;
    if (W !== 3'd3 || J !== 3'd5) begin
      errors++;
      $display("[TB] FAIL single_wj: got W=%0d J=%0d expected W=3 J=5", W, J);
    end
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_pending: got rsp_valid=%b busy=%b expected 0000 1", rsp_valid, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_rsp_valid: got %b expected %b", rsp_valid, 4'b0100);
    end
    checks++;
    if (rsp_cost !== 7'd42) begin
      errors++;
      $display("[TB] FAIL single_rsp_cost: got %0d expected 42", rsp_cost);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    setEngine(3, 1, 1, 1'b1);
    req = 4'b1010;
    for (int b = 0; b < 8; b++) begin
      setEngine(1, b, 7 - b, (b == 7));
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
        errors++;
        $display("[TB] FAIL burst_gnt beat %0d: got %b expected %b", b, gnt, 4'b0010);
      end
      tick();
      checks++;
      if (W !== IDW'(b) || J !== IDW'(7 - b)) begin
        errors++;
        $display("[TB] FAIL burst_wj beat %0d: got W=%0d J=%0d expected W=%0d J=%0d", b, W, J, b, 7 - b);
      end
      if (b > 0) begin
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_cost !== costOf(b - 1, 8 - b)) begin
          errors++;
          $display("[TB] FAIL burst_rsp beat %0d: got %b/%0d expected 0010/%0d", b - 1, rsp_valid, rsp_cost, costOf(b - 1, 8 - b));
        end
      end
    end
    req = 4'b1000;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL burst_handover_gnt: got %b expected %b", gnt, 4'b1000);
    end
    req = '0;
    tick();
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_cost !== costOf(7, 0)) begin
      errors++;
      $display("[TB] FAIL burst_last_rsp: got %b/%0d expected 0010/%0d", rsp_valid, rsp_cost, costOf(7, 0));
    end
  endtask

  task automatic test_round_robin();
    int rspCount [NREQ];
    int prev;
    do_reset();
    for (int e = 0; e < NREQ; e++) begin
      rspCount[e] = 0;
      setEngine(e, e, e, 1'b1);
    end
    req  = 4'b1111;
    prev = 0;
    for (int n = 0; n < 8; n++) begin
      #1;
      checks++;
      if (gnt !== (4'b0001 << (n % 4))) begin
        errors++;
        $display("[TB] FAIL rr_gnt cycle %0d: got %b expected %b", n, gnt, 4'b0001 << (n % 4));
      end
      tick();
      if (n > 0) begin
        checks++;
        if (rsp_valid !== (4'b0001 << prev) || rsp_cost !== costOf(prev, prev)) begin
          errors++;
          $display("[TB] FAIL rr_rsp cycle %0d: got %b/%0d expected %b/%0d", n, rsp_valid, rsp_cost, 4'b0001 << prev, costOf(prev, prev));
        end
      end
      for (int e = 0; e < NREQ; e++) if (rsp_valid[e]) rspCount[e]++;
      prev = n % 4;
    end
    req = '0;
    tick();
    for (int e = 0; e < NREQ; e++) if (rsp_valid[e]) rspCount[e]++;
    for (int e = 0; e < NREQ; e++) begin
      checks++;
      if (rspCount[e] != 2) begin
        errors++;
        $display("[TB] FAIL rr_count engine %0d: got %0d expected 2", e, rspCount[e]);
      end
    end
  endtask

  task automatic test_owner_bubble();
    do_reset();
    setEngine(1, 6, 6, 1'b1);
    req = 4'b0011;
    for (int b = 0; b < 2; b++) begin
      setEngine(0, b + 1, b + 2, 1'b0);
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL bubble_pre_gnt beat %0d: got %b expected 0001", b, gnt);
      end
      tick();
    end
    req = 4'b0010;
    setEngine(0, 7, 7, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL bubble_gnt cycle %0d: got %b expected 0001", c, gnt);
      end
      tick();
      checks++;
      if (W !== 3'd2 || J !== 3'd3 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bubble_hold cycle %0d: got W=%0d J=%0d busy=%b expected 2 3 1", c, W, J, busy);
      end
      checks++;
      if (rsp_valid !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL bubble_rsp cycle %0d: got %b expected %b", c, rsp_valid, (c == 0) ? 4'b0001 : 4'b0000);
      end
    end
    req = 4'b0011;
    for (int b = 2; b < 4; b++) begin
      setEngine(0, b + 1, b + 2, (b == 3));
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL bubble_post_gnt beat %0d: got %b expected 0001", b, gnt);
      end
      tick();
    end
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL bubble_release_gnt: got %b expected 0010", gnt);
    end
    req = '0;
    tick();
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_cost !== costOf(4, 5)) begin
      errors++;
      $display("[TB] FAIL bubble_last_rsp: got %b/%0d expected 0001/%0d", rsp_valid, rsp_cost, costOf(4, 5));
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    setEngine(2, 1, 1, 1'b1);
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    setEngine(0, 5, 5, 1'b0);
    req = 4'b0001;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_locked_busy: got %b expected 1", busy);
    end
    RST = 1'b0;
    req = '0;
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_cleared: got rsp_valid=%b busy=%b expected 0000 0", rsp_valid, busy);
    end
    checks++;
    if (W !== 3'd0 || J !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midrst_wj: got W=%0d J=%0d expected 0 0", W, J);
    end
    RST      = 1'b1;
    req_last = '0;
    req      = 4'b1010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL midrst_restart_gnt: got %b expected 0010", gnt);
    end
    req = '0;
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RST      = 1'b0;
    req      = '0;
    req_w    = '0;
    req_j    = '0;
    req_last = '0;
    test_reset();
    test_single_beat();
    test_burst_lock();
    test_round_robin();
    test_owner_bubble();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
